cc_speed_sequencer: RTL and testbench

- Tick-driven controller that sequences the cruise-control speed datapath.
- Owns the mode FSM and the current/set speed registers.
- Arbitrates four requesters by fixed priority: brake, collision hazard, driver accelerator, speed regulation.
- Feeds current_speed and set_speed to the existing 7-segment display logic, and drives cc_LED and LED_Warning.

---
 rtl/cc_speed_sequencer.sv | 143 ++++++++++++++
 tb/tb_cc_speed_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cc_speed_sequencer.sv
// Cruise-control speed sequencer: mode FSM, current/set speed registers and
// tick prescaler, arbitrating brake > hazard > accelerator > regulation.
//
// Ports:
//   clk, reset        : clock, async active-high reset
//   btn_enable        : active-low set/resume button (falling edge = press)
//   brake             : active-low brake pedal
//   accel             : active-high driver accelerator override
//   initial_speed     : manual-drive speed, tracked while OFF
//   speed_otherCar    : lead-car speed
//   distance          : gap to lead car
//   current_speed     : regulated vehicle speed
//   set_speed         : cruise target
//   cc_LED            : cruise engaged
//   LED_Warning       : hazard following active
//   state             : FSM state code
//   tick              : one-cycle speed-update strobe
module cc_speed_sequencer #(
  parameter int TICK_DIV    = 10000000,
  parameter int SAFE_DIST   = 10,
  parameter int FOLLOW_DIST = 20,
  parameter int MAX_SPEED   = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_enable,
  input  logic       brake,
  input  logic       accel,
  input  logic [5:0] initial_speed,
  input  logic [5:0] speed_otherCar,
  input  logic [4:0] distance,
  output logic [5:0] current_speed,
  output logic [5:0] set_speed,
  output logic       cc_LED,
  output logic       LED_Warning,
  output logic [2:0] state,
  output logic       tick
);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    HOLD      = 3'd1,
    SPEED_UP  = 3'd2,
    SLOW_DOWN = 3'd3,
    FOLLOW    = 3'd4
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [5:0] MAX_S = 6'(MAX_SPEED);
  localparam logic [4:0] SAFE_D = 5'(SAFE_DIST);
  localparam logic [4:0] FOLLOW_D = 5'(FOLLOW_DIST);

  state_t st_q, st_d;
  logic [PW-1:0] pcnt;
  logic btn_prev;
  logic [5:0] cur_q, cur_d;
  logic [5:0] set_q, set_d;
  logic press;
  logic hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (pcnt == PMAX) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign tick = (pcnt == PMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= OFF;
      cur_q    <= '0;
      set_q    <= '0;
      btn_prev <= 1'b1;
    end else begin
      st_q     <= st_d;
      cur_q    <= cur_d;
      set_q    <= set_d;
      btn_prev <= btn_enable;
    end
  end

  assign press = btn_prev & ~btn_enable;

  // A slower lead car only matters inside the follow window.
  assign hazard = (distance < SAFE_D) |
                  ((distance < FOLLOW_D) &
                   (speed_otherCar < cur_q));

  always_comb begin
    st_d  = st_q;
    cur_d = cur_q;
    set_d = set_q;
    case (st_q)
      OFF: begin
        cur_d = initial_speed;
        if (press) begin
          set_d = (initial_speed > MAX_S) ?
                  MAX_S : initial_speed;
          st_d  = HOLD;
        end
      end
      HOLD, SPEED_UP, SLOW_DOWN, FOLLOW: begin
        if (!brake) begin
          st_d  = OFF;
          set_d = '0;
        end else begin
          if (press) set_d = cur_q;
          if (hazard)              st_d = FOLLOW;
          else if (accel)          st_d = SPEED_UP;
          else if (cur_q > set_q)  st_d = SLOW_DOWN;
          else if (cur_q < set_q)  st_d = SPEED_UP;
          else                     st_d = HOLD;
        end
        // Step follows the registered state, not the one being chosen.
        if (tick) begin
          case (st_q)
            SPEED_UP:
              cur_d = (cur_q >= MAX_S) ?
                      MAX_S : cur_q + 6'd1;
            SLOW_DOWN, FOLLOW:
              cur_d = (cur_q == 6'd0) ?
                      6'd0 : cur_q - 6'd1;
            default: cur_d = cur_q;
          endcase
        end
      end
      default: st_d = OFF;
    endcase
  end

  assign current_speed = cur_q;
  assign set_speed     = set_q;
  assign state         = st_q;
  assign cc_LED        = (st_q != OFF);
  assign LED_Warning   = (st_q == FOLLOW);

endmodule

// File: tb/tb_cc_speed_sequencer.sv
// Randomized self-checking bench for cc_speed_sequencer against a
// cycle-level behavioural model, plus directed scenarios (TICK_DIV=4).
module tb_cc_speed_sequencer;

  localparam int TDIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_enable = 1'b1;
  logic brake = 1'b1;
  logic accel = 1'b0;
  logic [5:0] initial_speed = '0;
  logic [5:0] speed_otherCar = '0;
  logic [4:0] distance = 5'd31;
  logic [5:0] current_speed, set_speed;
  logic cc_LED, LED_Warning, tick;
  logic [2:0] state;

  cc_speed_sequencer #(
    .TICK_DIV(TDIV), .SAFE_DIST(10),
    .FOLLOW_DIST(20), .MAX_SPEED(63)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_enable(btn_enable), .brake(brake),
    .accel(accel), .initial_speed(initial_speed),
    .speed_otherCar(speed_otherCar),
    .distance(distance),
    .current_speed(current_speed),
    .set_speed(set_speed), .cc_LED(cc_LED),
    .LED_Warning(LED_Warning), .state(state),
    .tick(tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // model: mode 0=OFF 1=HOLD 2=SPEED_UP 3=SLOW_DOWN 4=FOLLOW
  int m_mode, m_cur, m_set, m_cnt, m_bprev;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_set = 0;
    m_cnt = 0; m_bprev = 1;
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_mode));
    chk("current_speed", 32'(current_speed), 32'(m_cur));
    chk("set_speed", 32'(set_speed), 32'(m_set));
    chk("tick", 32'(tick), 32'(m_cnt == TDIV - 1));
    chk("cc_LED", 32'(cc_LED), 32'(m_mode != 0));
    chk("LED_Warning", 32'(LED_Warning), 32'(m_mode == 4));
  endtask

  // One clock: check, advance model by current inputs, cross posedge.
  task automatic cyc();
    int nm, nc, ns;
    bit pr, hz, tk;
    check_all();
    tk = (m_cnt == TDIV - 1);
    pr = (m_bprev == 1) && !btn_enable;
    hz = (distance < 10) ||
         (distance < 20 && int'(speed_otherCar) < m_cur);
    nm = m_mode; nc = m_cur; ns = m_set;
    if (m_mode == 0) begin
      nc = initial_speed;
      if (pr) begin
        ns = (initial_speed > 63) ? 63 : int'(initial_speed);
        nm = 1;
      end
    end else begin
      if (!brake) begin
        nm = 0; ns = 0;
      end else begin
        if (pr) ns = m_cur;
        if (hz) nm = 4;
        else if (accel) nm = 2;
        else if (m_cur > m_set) nm = 3;
        else if (m_cur < m_set) nm = 2;
        else nm = 1;
      end
      if (tk && m_mode == 2) nc = (m_cur + 1 > 63) ? 63 : m_cur + 1;
      if (tk && (m_mode == 3 || m_mode == 4))
        nc = (m_cur - 1 < 0) ? 0 : m_cur - 1;
    end
    @(posedge clk);
    m_mode = nm; m_cur = nc; m_set = ns;
    m_cnt = (m_cnt + 1) % TDIV;
    m_bprev = btn_enable;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press_once();
    btn_enable = 1'b0; cyc();
    btn_enable = 1'b1;
  endtask

  task automatic engage_at(input int spd);
    brake = 1'b0; run(2);
    brake = 1'b1; initial_speed = 6'(spd); run(2);
    press_once(); run(1);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cur", 32'(current_speed), 32'd0);
    chk("rst_set", 32'(set_speed), 32'd0);
    chk("rst_leds", 32'({cc_LED, LED_Warning}), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int in_rng;

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // engage with a long button hold: exactly one capture
    initial_speed = 6'd30; distance = 5'd31;
    btn_enable = 1'b0; run(10);
    btn_enable = 1'b1; run(20);
    chk("engage_state", 32'(state), 32'd1);
    chk("engage_set", 32'(set_speed), 32'd30);
    chk("engage_cur", 32'(current_speed), 32'd30);

    // accelerator override, then regulate back down
    accel = 1'b1; run(12);
    accel = 1'b0; run(40);
    chk("return_state", 32'(state), 32'd1);
    chk("return_cur", 32'(current_speed), 32'd30);

    // follow slower lead car
    distance = 5'd15; speed_otherCar = 6'd20; run(50);
    in_rng = 1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      if (current_speed < 6'd20 || current_speed > 6'd21) in_rng = 0;
      chk("follow_set", 32'(set_speed), 32'd30);
    end
    chk("follow_range", 32'(in_rng), 32'd1);

    // saturation at 0
    distance = 5'd31; engage_at(2);
    distance = 5'd5; run(20);
    chk("sat0_cur", 32'(current_speed), 32'd0);
    chk("sat0_warn", 32'(LED_Warning), 32'd1);

    // saturation at 63
    distance = 5'd31; engage_at(62);
    accel = 1'b1; run(20);
    chk("sat63_cur", 32'(current_speed), 32'd63);
    accel = 1'b0; run(8);

    // brake and press together from HOLD
    chk("pre_brake_hold", 32'(state), 32'd1);
    initial_speed = 6'd17;
    brake = 1'b0; btn_enable = 1'b0; cyc();
    chk("brake_state", 32'(state), 32'd0);
    chk("brake_set", 32'(set_speed), 32'd0);
    chk("brake_led", 32'(cc_LED), 32'd0);
    cyc();
    chk("brake_cur", 32'(current_speed), 32'd17);
    brake = 1'b1; btn_enable = 1'b1; run(2);

    // async reset while in FOLLOW
    engage_at(25);
    distance = 5'd3; run(2);
    chk("pre_rst_follow", 32'(state), 32'd4);
    async_reset();
    distance = 5'd31;
    run(6);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) brake = ~brake;
      if (!brake && $urandom_range(0, 3) == 0) brake = 1'b1;
      if ($urandom_range(0, 5) == 0) btn_enable = ~btn_enable;
      if ($urandom_range(0, 7) == 0) accel = ~accel;
      if ($urandom_range(0, 9) == 0)
        distance = ($urandom_range(0, 1) == 1) ?
                   5'd31 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0)
        speed_otherCar = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0)
        initial_speed = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 799) == 0) async_reset();
      else cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
